// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state encoding and key-to-(column,row) map
// used by the keypad emulator and the matching column-scanning decoder.
package keypad_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_RELEASE} state_t;
   localparam logic [3:0] ROW_NONE = 4'hF;
   // Nibble k holds {column, row} of key k; the decoder uses the inverse lookup.
   localparam logic [15:0][3:0] KEY_MAP = 64'h7BFE_DCA6_2951_8403;
   function automatic logic [1:0] KEY_COL(input logic [3:0] k);
      return KEY_MAP[k][3:2];
   endfunction
   function automatic logic [1:0] KEY_ROW(input logic [3:0] k);
      return KEY_MAP[k][1:0];
   endfunction
endpackage

// File: rtl/keypad_col_hit.sv
// keypad_col_hit: one-hot-low column decode of the scan drive and a
// single-cycle hit pulse on the first cycle the target column is selected.
module keypad_col_hit
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_col,
   input  logic [1:0] i_tcol,
   output logic       o_sel,
   output logic       o_hit
);
   logic r_sel;
   logic w_valid;
   assign w_valid = $onehot(~i_col);
   assign o_sel   = w_valid && !i_col[i_tcol];
   assign o_hit   = o_sel && !r_sel;
   always_ff @(posedge clk) begin
      if (rst) r_sel <= 1'b0;
      else     r_sel <= o_sel;
   end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: plays the 4x4 keypad toward a column-scanning decoder,
// pressing a requested key for HOLD_SCANS hits then releasing for GAP_SCANS hits.
// Optional contact bounce at press/release edges via `define KEYEMU_BOUNCE_EN.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_SCANS = 4,
   parameter int GAP_SCANS  = 2,
   parameter int BOUNCE_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   output logic [3:0] row,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   output logic       pressed,
   output logic       busy
);
   if (HOLD_SCANS < 1 || HOLD_SCANS > 255 || GAP_SCANS < 1 || GAP_SCANS > 255 ||
       BOUNCE_LEN < 0 || BOUNCE_LEN > 255) begin : g_bad_param
      $error("keypad_emulator: HOLD_SCANS/GAP_SCANS must be 1..255, BOUNCE_LEN 0..255");
   end
   localparam logic [7:0] HOLD8 = 8'(HOLD_SCANS);
   localparam logic [7:0] GAP8  = 8'(GAP_SCANS);
   state_t     r_state, w_nstate;
   logic [7:0] r_cnt, w_ncnt, w_lim;
   logic [1:0] r_tcol, r_trow;
   logic [3:0] r_row, w_nrow;
   logic       w_sel, w_hit, w_accept, w_done, w_level;
   keypad_col_hit u_col_hit (
      .clk    (clk),
      .rst    (rst),
      .i_col  (col),
      .i_tcol (r_tcol),
      .o_sel  (w_sel),
      .o_hit  (w_hit)
   );
   assign key_ready = r_state == ST_IDLE;
   assign pressed   = r_state == ST_PRESS;
   assign busy      = r_state != ST_IDLE;
   assign row       = r_row;
   assign w_accept  = key_valid && key_ready;
`ifdef KEYEMU_BOUNCE_EN
   localparam logic [7:0] BLEN8 = 8'(BOUNCE_LEN);
   logic [7:0] r_bcnt;
   // Counts clk cycles since the last state entry; even counts read as contact closed.
   always_ff @(posedge clk) begin
      if (rst || w_nstate != r_state) r_bcnt <= '0;
      else if (r_bcnt < BLEN8)        r_bcnt <= r_bcnt + 8'd1;
   end
   assign w_level = (busy && r_bcnt < BLEN8) ? !r_bcnt[0] : pressed;
`else
   assign w_level = pressed;
`endif
   always_comb begin
      w_lim    = pressed ? HOLD8 : GAP8;
      w_done   = busy && w_hit && (r_cnt + 8'd1 == w_lim);
      w_nstate = w_accept ? ST_PRESS :
                 w_done   ? (pressed ? ST_RELEASE : ST_IDLE) : r_state;
      w_ncnt   = (w_accept || w_done) ? 8'd0 :
                 (busy && w_hit)      ? r_cnt + 8'd1 : r_cnt;
      w_nrow   = (w_sel && w_level) ? ~(4'b0001 << r_trow) : ROW_NONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_tcol  <= '0;
         r_trow  <= '0;
         r_row   <= ROW_NONE;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_row   <= w_nrow;
         if (w_accept) begin
            r_tcol <= KEY_COL(key_code);
            r_trow <= KEY_ROW(key_code);
         end
      end
   end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: table-driven directed vectors for keypad_emulator
// (default HOLD_SCANS=4, GAP_SCANS=2) plus hand-written reset sequences.
module tb_keypad_emulator;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] col = 4'hF;
   logic [3:0] row;
   logic [3:0] key_code = 4'h0;
   logic       key_valid = 1'b0;
   logic       key_ready, pressed, busy;
   int         n_chk = 0;
   int         n_err = 0;
   typedef struct {
      logic [3:0] col;
      logic       vld;
      logic [3:0] code;
      logic [3:0] row;
      logic       rdy;
      logic       prs;
      logic       bsy;
   } vec_t;
   vec_t tbl[$];
   keypad_emulator dut (
      .clk       (clk),
      .rst       (rst),
      .col       (col),
      .row       (row),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .pressed   (pressed),
      .busy      (busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic step(input logic [3:0] c, input logic v, input logic [3:0] k,
                       input logic [3:0] er, input logic erdy, input logic eprs,
                       input logic ebsy, input string nm);
      col = c;
      key_valid = v;
      key_code = k;
      @(posedge clk);
      #1;
      chk({nm, " row"}, row, er);
      chk({nm, " key_ready"}, {3'b0, key_ready}, {3'b0, erdy});
      chk({nm, " pressed"}, {3'b0, pressed}, {3'b0, eprs});
      chk({nm, " busy"}, {3'b0, busy}, {3'b0, ebsy});
   endtask
   function automatic void add(input logic [3:0] c, input logic v, input logic [3:0] k,
                               input logic [3:0] er, input logic erdy, input logic eprs,
                               input logic ebsy);
      vec_t e;
      e.col = c; e.vld = v; e.code = k; e.row = er; e.rdy = erdy; e.prs = eprs; e.bsy = ebsy;
      tbl.push_back(e);
   endfunction
   initial begin
      logic [3:0] pats [4];
      pats = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      // Key 5 = column 1 (col 1101), row 1 (row 1101); key_code changes after handshake are ignored.
      add(4'hF, 1, 4'h5, 4'hF, 0, 1, 1);
      repeat (3) begin
         add(4'b0111, 0, 4'h9, 4'hF, 0, 1, 1);
         add(4'b1011, 0, 4'h9, 4'hF, 0, 1, 1);
         add(4'b1101, 0, 4'h9, 4'b1101, 0, 1, 1);
         add(4'b1110, 0, 4'h9, 4'hF, 0, 1, 1);
      end
      add(4'b0111, 0, 4'h9, 4'hF, 0, 1, 1);
      add(4'b1011, 0, 4'h9, 4'hF, 0, 1, 1);
      add(4'b1101, 0, 4'h9, 4'b1101, 0, 0, 1);
      add(4'b1110, 0, 4'h9, 4'hF, 0, 0, 1);
      add(4'b0111, 1, 4'h7, 4'hF, 0, 0, 1);
      add(4'b1011, 1, 4'h7, 4'hF, 0, 0, 1);
      add(4'b1101, 1, 4'h7, 4'hF, 0, 0, 1);
      add(4'b1110, 1, 4'h7, 4'hF, 0, 0, 1);
      add(4'b0111, 0, 4'h7, 4'hF, 0, 0, 1);
      add(4'b1011, 0, 4'h7, 4'hF, 0, 0, 1);
      add(4'b1101, 0, 4'h7, 4'hF, 1, 0, 0);
      add(4'b1110, 0, 4'h7, 4'hF, 1, 0, 0);
      // Key D = column 3 (col 0111), row 3 (row 0111).
      add(4'hF, 1, 4'hD, 4'hF, 0, 1, 1);
      repeat (3) begin
         add(4'b1110, 0, 4'h0, 4'hF, 0, 1, 1);
         add(4'b0111, 0, 4'h0, 4'b0111, 0, 1, 1);
      end
      add(4'b1110, 0, 4'h0, 4'hF, 0, 1, 1);
      add(4'b0111, 0, 4'h0, 4'b0111, 0, 0, 1);
      add(4'b1110, 0, 4'h0, 4'hF, 0, 0, 1);
      add(4'b0111, 0, 4'h0, 4'hF, 0, 0, 1);
      add(4'b1110, 0, 4'h0, 4'hF, 0, 0, 1);
      add(4'b0111, 0, 4'h0, 4'hF, 1, 0, 0);
      // Key 8 = column 1, row 2 (row 1011); key 3 requested while busy must be ignored.
      add(4'hF, 1, 4'h8, 4'hF, 0, 1, 1);
      repeat (3) begin
         add(4'b1011, 1, 4'h3, 4'hF, 0, 1, 1);
         add(4'b1101, 1, 4'h3, 4'b1011, 0, 1, 1);
         add(4'b1110, 1, 4'h3, 4'hF, 0, 1, 1);
      end
      add(4'b1011, 1, 4'h3, 4'hF, 0, 1, 1);
      add(4'b1101, 1, 4'h3, 4'b1011, 0, 0, 1);
      add(4'b1110, 1, 4'h3, 4'hF, 0, 0, 1);
      add(4'b1101, 1, 4'h3, 4'hF, 0, 0, 1);
      add(4'b1110, 1, 4'h3, 4'hF, 0, 0, 1);
      add(4'b1101, 0, 4'h3, 4'hF, 1, 0, 0);
      // Key 3 = column 2 (col 1011), row 0 (row 1110), now accepted.
      add(4'b1110, 1, 4'h3, 4'hF, 0, 1, 1);
      add(4'b1011, 0, 4'h3, 4'b1110, 0, 1, 1);
      add(4'hF, 0, 4'h3, 4'hF, 0, 1, 1);
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset row", row, 4'hF);
      chk("reset key_ready", {3'b0, key_ready}, 4'h1);
      chk("reset pressed", {3'b0, pressed}, 4'h0);
      chk("reset busy", {3'b0, busy}, 4'h0);
      rst = 1'b0;
      // Idle scan: no key appears on any column.
      for (int p = 0; p < 4; p++)
         repeat (4) step(pats[p], 0, 4'h0, 4'hF, 1, 0, 0, $sformatf("idle col%b", pats[p]));
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].col, tbl[i].vld, tbl[i].code, tbl[i].row, tbl[i].rdy, tbl[i].prs,
              tbl[i].bsy, $sformatf("vec%0d", i));
      // Reset while key 3 is held, then a key 1 press aborted by reset.
      rst = 1'b1;
      step(4'hF, 0, 4'h0, 4'hF, 1, 0, 0, "rst busy");
      rst = 1'b0;
      step(4'hF, 1, 4'h1, 4'hF, 0, 1, 1, "key1 accept");
      step(4'b1110, 0, 4'h0, 4'b1110, 0, 1, 1, "key1 hit");
      step(4'hF, 0, 4'h0, 4'hF, 0, 1, 1, "key1 gap");
      rst = 1'b1;
      step(4'b1110, 0, 4'h0, 4'hF, 1, 0, 0, "key1 rst");
      rst = 1'b0;
      repeat (4) begin
         step(4'hF, 0, 4'h0, 4'hF, 1, 0, 0, "post rst idle");
         step(4'b1110, 0, 4'h0, 4'hF, 1, 0, 0, "post rst col0");
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
